// File: rtl/node_expander.sv
// Grid node expander: emits the 8-connected successors of one node
// with g/h/f costs, using one obstacle-map read per in-bounds neighbour.
package node_pkg;
    localparam int NODE_XW = 8;
    localparam int NODE_YW = 8;
    localparam int NODE_CW = 16;

    typedef struct packed {
        logic [NODE_XW-1:0] x;
        logic [NODE_YW-1:0] y;
        logic [NODE_CW-1:0] g;
        logic [NODE_CW-1:0] h;
        logic [NODE_CW-1:0] f;
        logic [2:0]         parent_dir;
    } node_array_t;
endpackage

module node_expander
    import node_pkg::*;
#(
    parameter int GRID_W = 256,
    parameter int GRID_H = 256,
    parameter int COST_W = 16,
    parameter int ADDR_W = $clog2(GRID_W * GRID_H)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  node_array_t               node_in,
    input  logic                      node_in_valid,
    output logic                      node_in_ready,
    input  logic [$clog2(GRID_W)-1:0] goal_x,
    input  logic [$clog2(GRID_H)-1:0] goal_y,
    output logic                      map_rd_en,
    output logic [ADDR_W-1:0]         map_rd_addr,
    input  logic                      map_rd_data,
    output node_array_t [15:0]        new_nodes,
    output logic [15:0]               new_nodes_valid,
    output logic                      new_nodes_strobe,
    output logic                      goal_found
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    // Direction masks, bit k = neighbour k (E,N,W,S,NE,NW,SW,SE)
    localparam logic [7:0] XP = 8'b1001_0001;
    localparam logic [7:0] XM = 8'b0110_0100;
    localparam logic [7:0] YM = 8'b0011_0010;
    localparam logic [7:0] YP = 8'b1100_1000;
    localparam logic [COST_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, EMIT} state_t;

    state_t             state;
    state_t             state_nx;
    logic [2:0]         k;
    logic [XW-1:0]      px;
    logic [YW-1:0]      py;
    logic [COST_W-1:0]  pg;
    logic [7:0]         free;
    logic               goal_q;
    node_array_t [15:0] nodes_q;
    logic [7:0]         valid_q;

    logic [XW-1:0]      nx [8];
    logic [YW-1:0]      ny [8];
    logic [ADDR_W-1:0]  addr [8];
    logic [7:0]         inb;
    logic [7:0]         free_d;
    logic [7:0]         vld;
    node_array_t [15:0] slots;
    logic               accept;
    logic               at_goal;

    function automatic logic [COST_W-1:0] sat_add(
        input logic [COST_W-1:0] a,
        input logic [COST_W-1:0] b
    );
        logic [COST_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COST_W] ? CMAX : s[COST_W-1:0];
    endfunction

    function automatic logic [COST_W-1:0] heur(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y,
        input logic [XW-1:0] gx,
        input logic [YW-1:0] gy
    );
        logic [31:0] dx;
        logic [31:0] dy;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] h;
        dx = (x >= gx) ? 32'(x - gx) : 32'(gx - x);
        dy = (y >= gy) ? 32'(y - gy) : 32'(gy - y);
        hi = (dx > dy) ? dx : dy;
        lo = (dx > dy) ? dy : dx;
        h  = 32'd10 * hi + 32'd4 * lo;
        return (h > 32'(CMAX)) ? CMAX : h[COST_W-1:0];
    endfunction

    assign accept  = node_in_valid && node_in_ready;
    assign at_goal = (node_in.x == goal_x) && (node_in.y == goal_y);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            nx[i] = px;
            ny[i] = py;
            if (XP[i]) nx[i] = px + XW'(1);
            if (XM[i]) nx[i] = px - XW'(1);
            if (YP[i]) ny[i] = py + YW'(1);
            if (YM[i]) ny[i] = py - YW'(1);
            inb[i] = !(XP[i] && px == XW'(GRID_W - 1)) &&
                     !(XM[i] && px == '0) &&
                     !(YP[i] && py == YW'(GRID_H - 1)) &&
                     !(YM[i] && py == '0);
            addr[i] = (ADDR_W'(ny[i]) << XW) | ADDR_W'(nx[i]);
        end
    end

    // The last neighbour's map bit arrives during DRAIN, so merge it live
    always_comb begin
        free_d    = free;
        free_d[7] = inb[7] && !map_rd_data;
        vld[3:0]  = free_d[3:0];
        vld[4]    = free_d[4] && free_d[0] && free_d[1];
        vld[5]    = free_d[5] && free_d[1] && free_d[2];
        vld[6]    = free_d[6] && free_d[2] && free_d[3];
        vld[7]    = free_d[7] && free_d[3] && free_d[0];
        slots     = '0;
        for (int i = 0; i < 8; i++) begin
            if (vld[i]) begin
                slots[i].x = nx[i];
                slots[i].y = ny[i];
                slots[i].g = sat_add(pg, (i < 4) ? COST_W'(10) : COST_W'(14));
                slots[i].h = heur(nx[i], ny[i], goal_x, goal_y);
                slots[i].f = sat_add(slots[i].g, slots[i].h);
                slots[i].parent_dir = 3'(i) ^ 3'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept && !at_goal) state_nx = READ;
            READ:    if (k == 3'd7) state_nx = DRAIN;
            DRAIN:   state_nx = EMIT;
            EMIT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        node_in_ready    = 1'b0;
        map_rd_en        = 1'b0;
        map_rd_addr      = '0;
        new_nodes_strobe = 1'b0;
        unique case (1'b1)
            (state == IDLE): node_in_ready = 1'b1;
            (state == READ): begin
                map_rd_en   = inb[k];
                map_rd_addr = inb[k] ? addr[k] : '0;
            end
            (state == EMIT): new_nodes_strobe = 1'b1;
            default: ;
        endcase
    end

    assign new_nodes_valid = new_nodes_strobe ? {8'h00, valid_q} : 16'h0000;
    assign new_nodes       = nodes_q;
    assign goal_found      = goal_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k       <= '0;
            px      <= '0;
            py      <= '0;
            pg      <= '0;
            free    <= '0;
            goal_q  <= 1'b0;
            nodes_q <= '0;
            valid_q <= '0;
        end else begin
            goal_q <= accept && at_goal;
            if (accept) begin
                px <= node_in.x;
                py <= node_in.y;
                pg <= node_in.g;
                k  <= '0;
            end
            if (state == READ) begin
                k <= k + 3'd1;
                if (k != 3'd0) free[k - 3'd1] <= inb[k - 3'd1] && !map_rd_data;
            end
            if (state == DRAIN) begin
                free    <= free_d;
                nodes_q <= slots;
                valid_q <= vld;
            end
        end
    end
endmodule

// File: tb/tb_node_expander.sv
// Scoreboard bench for node_expander: a reference model predicts each
// batch at send time; batches are popped and compared on the strobe.
module tb_node_expander;
    import node_pkg::*;

    typedef struct {
        logic [15:0]        valid;
        node_array_t [15:0] nodes;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    node_array_t        node_in;
    logic               node_in_valid;
    logic               node_in_ready;
    logic [7:0]         goal_x;
    logic [7:0]         goal_y;
    logic               map_rd_en;
    logic [15:0]        map_rd_addr;
    logic               map_rd_data;
    node_array_t [15:0] new_nodes;
    logic [15:0]        new_nodes_valid;
    logic               new_nodes_strobe;
    logic               goal_found;

    logic obst [65536];
    exp_t sb [$];

    int checks = 0;
    int errors = 0;
    int strobe_cyc, strobe_cnt, goal_cyc, goal_cnt;
    int rd_cnt, busy_cnt, stray;
    logic [15:0]        cap_valid;
    node_array_t [15:0] cap_nodes;

    node_expander dut (
        .clk(clk), .rst(rst),
        .node_in(node_in), .node_in_valid(node_in_valid),
        .node_in_ready(node_in_ready),
        .goal_x(goal_x), .goal_y(goal_y),
        .map_rd_en(map_rd_en), .map_rd_addr(map_rd_addr),
        .map_rd_data(map_rd_data),
        .new_nodes(new_nodes), .new_nodes_valid(new_nodes_valid),
        .new_nodes_strobe(new_nodes_strobe), .goal_found(goal_found)
    );

    always #5 clk = ~clk;

    always @(posedge clk) map_rd_data <= map_rd_en ? obst[map_rd_addr] : 1'b0;

    function automatic exp_t model(input int x, input int y, input int g);
        int ddx [8] = '{1, 0, -1, 0, 1, -1, -1, 1};
        int ddy [8] = '{0, -1, 0, 1, -1, -1, 1, 1};
        int pdt [8] = '{2, 3, 0, 1, 6, 7, 4, 5};
        bit fr [8];
        bit ok;
        int nx, ny, gg, dx, dy, hh, ff;
        exp_t e;
        e.valid = '0;
        e.nodes = '0;
        for (int k = 0; k < 8; k++) begin
            nx = x + ddx[k];
            ny = y + ddy[k];
            fr[k] = 1'b0;
            if (nx >= 0 && nx < 256 && ny >= 0 && ny < 256)
                fr[k] = !obst[ny * 256 + nx];
        end
        for (int k = 0; k < 8; k++) begin
            ok = fr[k];
            if (k >= 4) ok = ok && fr[(ddx[k] > 0) ? 0 : 2] && fr[(ddy[k] < 0) ? 1 : 3];
            if (ok) begin
                nx = x + ddx[k];
                ny = y + ddy[k];
                gg = g + ((k < 4) ? 10 : 14);
                if (gg > 65535) gg = 65535;
                dx = (nx > int'(goal_x)) ? nx - int'(goal_x) : int'(goal_x) - nx;
                dy = (ny > int'(goal_y)) ? ny - int'(goal_y) : int'(goal_y) - ny;
                hh = (dx > dy) ? 10 * dx + 4 * dy : 10 * dy + 4 * dx;
                if (hh > 65535) hh = 65535;
                ff = gg + hh;
                if (ff > 65535) ff = 65535;
                e.valid[k] = 1'b1;
                e.nodes[k].x = 8'(nx);
                e.nodes[k].y = 8'(ny);
                e.nodes[k].g = 16'(gg);
                e.nodes[k].h = 16'(hh);
                e.nodes[k].f = 16'(ff);
                e.nodes[k].parent_dir = 3'(pdt[k]);
            end
        end
        return e;
    endfunction

    task automatic clear_obs();
        strobe_cyc = 0; strobe_cnt = 0; goal_cyc = 0; goal_cnt = 0;
        rd_cnt = 0; busy_cnt = 0; stray = 0;
        cap_valid = '0; cap_nodes = '0;
    endtask

    task automatic sample(input int c);
        if (goal_found) begin goal_cnt++; goal_cyc = c; end
        if (map_rd_en) rd_cnt++;
        if (!node_in_ready) busy_cnt++;
        if (new_nodes_valid != 16'h0 && !new_nodes_strobe) stray++;
        if (new_nodes_strobe) begin
            strobe_cnt++;
            strobe_cyc = c;
            cap_valid = new_nodes_valid;
            cap_nodes = new_nodes;
        end
    endtask

    // Drives one node and records 14 cycles of observations; no checking
    task automatic send_node(input int x, input int y, input int g, input bit push);
        @(negedge clk);
        node_in = '0;
        node_in.x = 8'(x);
        node_in.y = 8'(y);
        node_in.g = 16'(g);
        node_in_valid = 1'b1;
        if (push) sb.push_back(model(x, y, g));
        clear_obs();
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) node_in_valid = 1'b0;
            sample(c);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({map_rd_en, new_nodes_strobe, goal_found} !== 3'b000 ||
            new_nodes_valid !== 16'h0 || map_rd_addr !== 16'h0 || new_nodes !== '0) begin
            errors++;
            $display("FAIL reset_outputs en=%b stb=%b goal=%b valid=%h addr=%h want all 0",
                     map_rd_en, new_nodes_strobe, goal_found, new_nodes_valid, map_rd_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (node_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", node_in_ready);
        end
        e.valid = '0;
    endtask

    task automatic test_basic();
        exp_t e;
        goal_x = 8'd9; goal_y = 8'd7;
        send_node(5, 5, 20, 1'b1);
        checks++;
        if (strobe_cyc !== 10 || strobe_cnt !== 1) begin
            errors++;
            $display("FAIL basic_strobe cyc=%0d cnt=%0d want cyc=10 cnt=1", strobe_cyc, strobe_cnt);
        end
        checks++;
        if (rd_cnt !== 8 || busy_cnt !== 10 || stray !== 0) begin
            errors++;
            $display("FAIL basic_timing reads=%0d busy=%0d stray=%0d want 8 10 0",
                     rd_cnt, busy_cnt, stray);
        end
        checks++;
        if (cap_valid !== 16'h00FF) begin
            errors++;
            $display("FAIL basic_valid got %h want 00ff", cap_valid);
        end
        checks++;
        if (cap_nodes[0].x !== 8'd6 || cap_nodes[0].y !== 8'd5 || cap_nodes[0].g !== 16'd30 ||
            cap_nodes[0].h !== 16'd38 || cap_nodes[0].f !== 16'd68 || cap_nodes[0].parent_dir !== 3'd2) begin
            errors++;
            $display("FAIL basic_e_slot got x=%0d y=%0d g=%0d h=%0d f=%0d pd=%0d want 6 5 30 38 68 2",
                     cap_nodes[0].x, cap_nodes[0].y, cap_nodes[0].g, cap_nodes[0].h,
                     cap_nodes[0].f, cap_nodes[0].parent_dir);
        end
        checks++;
        if (cap_nodes[4].x !== 8'd6 || cap_nodes[4].y !== 8'd4 || cap_nodes[4].g !== 16'd34 ||
            cap_nodes[4].h !== 16'd42 || cap_nodes[4].f !== 16'd76 || cap_nodes[4].parent_dir !== 3'd6) begin
            errors++;
            $display("FAIL basic_ne_slot got x=%0d y=%0d g=%0d h=%0d f=%0d pd=%0d want 6 4 34 42 76 6",
                     cap_nodes[4].x, cap_nodes[4].y, cap_nodes[4].g, cap_nodes[4].h,
                     cap_nodes[4].f, cap_nodes[4].parent_dir);
        end
        checks++;
        e = sb.pop_front();
        if (cap_valid !== e.valid || cap_nodes !== e.nodes) begin
            errors++;
            $display("FAIL basic_batch valid got %h want %h", cap_valid, e.valid);
        end
    endtask

    task automatic test_corner();
        exp_t e;
        send_node(0, 0, 0, 1'b1);
        checks++;
        if (rd_cnt !== 3 || cap_valid !== 16'h0089) begin
            errors++;
            $display("FAIL corner reads=%0d valid=%h want 3 0089", rd_cnt, cap_valid);
        end
        checks++;
        e = sb.pop_front();
        if (strobe_cnt !== 1 || cap_valid !== e.valid || cap_nodes !== e.nodes) begin
            errors++;
            $display("FAIL corner_batch strobes=%0d valid got %h want %h", strobe_cnt, cap_valid, e.valid);
        end
    endtask

    task automatic test_obstacle();
        exp_t e;
        obst[5 * 256 + 6] = 1'b1;
        send_node(5, 5, 20, 1'b1);
        checks++;
        if ((cap_valid & 16'h0091) !== 16'h0 || strobe_cnt !== 1) begin
            errors++;
            $display("FAIL obstacle_cut valid=%h strobes=%0d want E/NE/SE clear and 1 strobe",
                     cap_valid, strobe_cnt);
        end
        checks++;
        e = sb.pop_front();
        if (cap_valid !== e.valid || cap_nodes !== e.nodes) begin
            errors++;
            $display("FAIL obstacle_batch valid got %h want %h", cap_valid, e.valid);
        end
        obst[5 * 256 + 6] = 1'b0;
    endtask

    task automatic test_goal();
        send_node(9, 7, 0, 1'b0);
        checks++;
        if (goal_cyc !== 1 || goal_cnt !== 1) begin
            errors++;
            $display("FAIL goal_pulse cyc=%0d cnt=%0d want 1 1", goal_cyc, goal_cnt);
        end
        checks++;
        if (rd_cnt !== 0 || strobe_cnt !== 0 || busy_cnt !== 0) begin
            errors++;
            $display("FAIL goal_idle reads=%0d strobes=%0d busy=%0d want 0 0 0",
                     rd_cnt, strobe_cnt, busy_cnt);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        send_node(5, 5, 32'hFFF8, 1'b1);
        checks++;
        if (cap_nodes[0].g !== 16'hFFFF || cap_nodes[0].f !== 16'hFFFF ||
            cap_nodes[4].g !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate g=%h f=%h diag_g=%h want ffff ffff ffff",
                     cap_nodes[0].g, cap_nodes[0].f, cap_nodes[4].g);
        end
        checks++;
        e = sb.pop_front();
        if (cap_valid !== e.valid || cap_nodes !== e.nodes) begin
            errors++;
            $display("FAIL saturate_batch valid got %h want %h", cap_valid, e.valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int stb;
        stb = 0;
        @(negedge clk);
        node_in = '0;
        node_in.x = 8'd5;
        node_in.y = 8'd5;
        node_in.g = 16'd20;
        node_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        node_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({map_rd_en, new_nodes_strobe, goal_found} !== 3'b000 ||
            new_nodes_valid !== 16'h0 || map_rd_addr !== 16'h0 || new_nodes !== '0) begin
            errors++;
            $display("FAIL midreset_outputs en=%b stb=%b goal=%b valid=%h addr=%h want all 0",
                     map_rd_en, new_nodes_strobe, goal_found, new_nodes_valid, map_rd_addr);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b1;
            if (new_nodes_strobe) stb++;
        end
        checks++;
        if (stb !== 0) begin
            errors++;
            $display("FAIL midreset_no_strobe got %0d strobes want 0", stb);
        end
        send_node(5, 5, 20, 1'b1);
        checks++;
        e = sb.pop_front();
        if (strobe_cyc !== 10 || cap_valid !== e.valid || cap_nodes !== e.nodes) begin
            errors++;
            $display("FAIL midreset_recover cyc=%0d valid got %h want cyc=10 valid %h",
                     strobe_cyc, cap_valid, e.valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int acc_c, s1, s2, ns;
        acc_c = 0; s1 = 0; s2 = 0; ns = 0;
        @(negedge clk);
        node_in = '0;
        node_in.x = 8'd3;
        node_in.y = 8'd3;
        node_in_valid = 1'b1;
        sb.push_back(model(3, 3, 0));
        sb.push_back(model(200, 100, 50));
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                node_in.x = 8'd200;
                node_in.y = 8'd100;
                node_in.g = 16'd50;
            end
            if (new_nodes_strobe) begin
                ns++;
                if (ns == 1) s1 = c; else s2 = c;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_batch unexpected strobe at cycle %0d", c);
                end else begin
                    e = sb.pop_front();
                    if (new_nodes_valid !== e.valid || new_nodes !== e.nodes) begin
                        errors++;
                        $display("FAIL b2b_batch valid got %h want %h", new_nodes_valid, e.valid);
                    end
                end
            end
            if (acc_c != 0 && c == acc_c + 1) node_in_valid = 1'b0;
            if (acc_c == 0 && node_in_valid && node_in_ready) acc_c = c;
        end
        node_in_valid = 1'b0;
        checks++;
        if (acc_c !== 11 || s1 !== 10 || s2 !== 21 || ns !== 2) begin
            errors++;
            $display("FAIL b2b_timing accept=%0d s1=%0d s2=%0d n=%0d want 11 10 21 2",
                     acc_c, s1, s2, ns);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) obst[i] = 1'b0;
        node_in = '0;
        node_in_valid = 1'b0;
        goal_x = 8'd9;
        goal_y = 8'd7;
        test_reset();
        test_basic();
        test_corner();
        test_obstacle();
        test_goal();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
